// File: rtl/feistel_pkg.sv
// Shared types and helpers for the iterative Feistel cipher core.
package feistel_pkg;

  localparam int DEFAULT_HALF_W = 4;
  localparam int DEFAULT_ROUNDS = 4;

  // Widest block the rotate helper handles (so HALF_W may go up to 32).
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic [MAX_W-1:0] word_t;

  // Rotate the low w bits of x left by amt (amt wraps modulo w); bits at
  // and above w come back as zero so callers can simply truncate.
  function automatic word_t rotl(input word_t x, input int amt, input int w);
    word_t res;
    int    shift;
    int    src;
    res   = '0;
    shift = amt % w;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        src    = (i + w - shift) % w;
        res[i] = |((x >> src) & word_t'(1));
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/feistel_cipher_core_round.sv
// One combinational Feistel round: expansion, key mix, modular add and swap.
module feistel_round
  import feistel_pkg::*;
#(
  parameter int HALF_W = DEFAULT_HALF_W
) (
  input  logic [HALF_W-1:0]   l,
  input  logic [HALF_W-1:0]   r,
  input  logic [2*HALF_W-1:0] k,
  output logic [HALF_W-1:0]   l_next,
  output logic [HALF_W-1:0]   r_next
);

  logic [HALF_W-1:0]   r_rot;
  logic [HALF_W-1:0]   f;
  logic [2*HALF_W-1:0] e;
  logic [2*HALF_W-1:0] x;

  // Round function F(R, k) folded back to HALF_W bits, then the half swap.
  always_comb begin
    r_rot  = HALF_W'(rotl(word_t'(r), 1, HALF_W));
    e      = {r_rot, r};
    x      = e ^ k;
    f      = x[2*HALF_W-1:HALF_W] + x[HALF_W-1:0] + HALF_W'(k[0]);
    l_next = r;
    r_next = l ^ f;
  end

endmodule

// File: rtl/feistel_cipher_core.sv
// Iterative Feistel cipher: one block in flight, one round per clock,
// valid/ready on both sides. Decrypt reuses the datapath with the round
// keys applied in reverse order.
module feistel_cipher_core
  import feistel_pkg::*;
#(
  parameter int HALF_W = DEFAULT_HALF_W,
  parameter int ROUNDS = DEFAULT_ROUNDS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*HALF_W-1:0] in_data,
  input  logic [2*HALF_W-1:0] in_key,
  input  logic                in_decrypt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*HALF_W-1:0] out_data
);

  localparam int BLK_W = 2 * HALF_W;
  localparam int CNT_W = $clog2(ROUNDS) + 1;
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [HALF_W-1:0]  l_q;
  logic [HALF_W-1:0]  r_q;
  logic [HALF_W-1:0]  l_next;
  logic [HALF_W-1:0]  r_next;
  logic [BLK_W-1:0]   key_q;
  logic [BLK_W-1:0]   key_i;
  logic [BLK_W-1:0]   out_q;
  logic               dec_q;
  logic               last_round;
  int                 round_idx;

  // Round key for the current step; decrypt walks the key schedule backwards.
  always_comb begin
    round_idx = dec_q ? (ROUNDS - 1 - int'(cnt)) : int'(cnt);
    key_i     = BLK_W'(rotl(word_t'(key_q), round_idx, BLK_W));
  end

  assign last_round = (cnt == LAST_ROUND);
  assign out_data   = out_q;

  feistel_round #(
    .HALF_W (HALF_W)
  ) u_round (
    .l      (l_q),
    .r      (r_q),
    .k      (key_i),
    .l_next (l_next),
    .r_next (r_next)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !reset;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last_round) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Block capture, round iteration and result register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      l_q   <= '0;
      r_q   <= '0;
      key_q <= '0;
      dec_q <= 1'b0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            l_q   <= in_data[BLK_W-1:HALF_W];
            r_q   <= in_data[HALF_W-1:0];
            key_q <= in_key;
            dec_q <= in_decrypt;
            cnt   <= '0;
          end
        end
        RUN: begin
          l_q <= l_next;
          r_q <= r_next;
          cnt <= cnt + 1'b1;
          if (last_round) out_q <= {r_next, l_next};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_feistel_cipher_core.sv
// Self-checking bench: runs several HALF_W/ROUNDS configurations side by side,
// each with its own scoreboard queue fed from an independent reference model.
module tb_feistel_cipher_core;

  localparam int NCFG = 8;

  logic clock = 1'b0;
  int   assertCount = 0;
  int   failCount = 0;
  wire  [NCFG-1:0] done_vec;

  always #5 clock = ~clock;

  function automatic int cfg_hw(input int g);
    case (g)
      0, 1:    return 4;
      2, 3, 4: return 2;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_rn(input int g);
    case (g)
      0:       return 4;
      1, 2, 5: return 1;
      3, 6:    return 3;
      default: return 20;
    endcase
  endfunction

  // Reference cipher written directly from the algorithm with integer math.
  function automatic int ref_cipher(input int hw, input int rn, input int data,
                                    input int key, input bit dec);
    int mask, bw, bmask, l, r, t, i, a, k, e, x, f;
    mask  = (1 << hw) - 1;
    bw    = 2 * hw;
    bmask = (1 << bw) - 1;
    l     = (data >> hw) & mask;
    r     = data & mask;
    for (int j = 0; j < rn; j++) begin
      i = dec ? (rn - 1 - j) : j;
      a = i % bw;
      k = ((key << a) | (key >> (bw - a))) & bmask;
      e = ((((r << 1) | (r >> (hw - 1))) & mask) << hw) | r;
      x = e ^ k;
      f = ((x >> hw) + (x & mask) + (k & 1)) & mask;
      t = r;
      r = l ^ f;
      l = t;
    end
    return (r << hw) | l;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
    localparam int HW = cfg_hw(g);
    localparam int RN = cfg_rn(g);
    localparam int BW = 2 * HW;
    localparam int NPAIRS = 12000 / (RN + 2);

    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic [BW-1:0] in_key;
    logic          in_decrypt;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic [BW-1:0] exp_q[$];
    bit            finished = 1'b0;

    assign done_vec[g] = finished;

    feistel_cipher_core #(
      .HALF_W (HW),
      .ROUNDS (RN)
    ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_key     (in_key),
      .in_decrypt (in_decrypt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data)
    );

    function automatic string tag(input string s);
      return $sformatf("h%0d_r%0d_%s", HW, RN, s);
    endfunction

    // Offer one block at a negedge; on acceptance push its expected result.
    task automatic applyStimulus(input logic [BW-1:0] data, input logic [BW-1:0] key,
                                 input logic dec, input logic [BW-1:0] expv,
                                 input bit track);
      int waited = 0;
      while (!in_ready && waited < 8) begin
        @(negedge clock);
        waited++;
      end
      if (!in_ready) begin
        checkOutput(tag("in_ready_wait"), 64'(in_ready), 64'(1));
      end else begin
        in_valid   = 1'b1;
        in_data    = data;
        in_key     = key;
        in_decrypt = dec;
        @(posedge clock);
        if (track) exp_q.push_back(expv);
        @(negedge clock);
        in_valid   = 1'b0;
        in_data    = ~data;
        in_key     = ~key;
        in_decrypt = ~dec;
      end
    endtask

    // Wait for the result, check latency and data, optionally stall, then take it.
    task automatic collectResult(input int hold);
      int            lat = 0;
      logic [BW-1:0] expv;
      do begin
        @(posedge clock);
        lat++;
        @(negedge clock);
      end while (!out_valid && lat < RN + 6);
      checkOutput(tag("latency"), 64'(lat), 64'(RN));
      if (exp_q.size() == 0) begin
        checkOutput(tag("scoreboard_empty"), 64'(exp_q.size()), 64'(1));
        expv = '0;
      end else begin
        expv = exp_q.pop_front();
      end
      checkOutput(tag("out_data"), 64'(out_data), 64'(expv));
      for (int c = 0; c < hold; c++) begin
        out_ready = 1'b0;
        in_valid  = 1'($urandom);
        in_data   = BW'($urandom);
        @(negedge clock);
        checkOutput(tag("hold_out_data"), 64'(out_data), 64'(expv));
        checkOutput(tag("hold_out_valid"), 64'(out_valid), 64'(1));
        checkOutput(tag("hold_in_ready"), 64'(in_ready), 64'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      out_ready = 1'b0;
      checkOutput(tag("post_hs_in_ready"), 64'(in_ready), 64'(1));
      checkOutput(tag("post_hs_out_valid"), 64'(out_valid), 64'(0));
    endtask

    initial begin
      logic [BW-1:0] data;
      logic [BW-1:0] key;
      logic [BW-1:0] ct;
      logic          any_valid;

      reset      = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      in_data    = '0;
      in_key     = '0;
      in_decrypt = 1'b0;
      @(negedge clock);
      checkOutput(tag("in_ready_in_reset"), 64'(in_ready), 64'(0));
      @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput(tag("rst_out_valid"), 64'(out_valid), 64'(0));
      checkOutput(tag("rst_out_data"), 64'(out_data), 64'(0));
      checkOutput(tag("rst_in_ready"), 64'(in_ready), 64'(1));

      // Known vector and its inverse.
      data = BW'(16'h0046);
      key  = BW'(16'h0093);
      ct   = BW'(ref_cipher(HW, RN, int'(data), int'(key), 1'b0));
      applyStimulus(data, key, 1'b0, ct, 1'b1);
      collectResult(0);
      applyStimulus(ct, key, 1'b1, data, 1'b1);
      collectResult(0);

      // Backpressure with noise on the input side.
      data = BW'($urandom);
      key  = BW'($urandom);
      applyStimulus(data, key, 1'b0, BW'(ref_cipher(HW, RN, int'(data), int'(key), 1'b0)), 1'b1);
      collectResult(10);
      any_valid = 1'b0;
      repeat (RN + 3) begin
        @(negedge clock);
        any_valid = any_valid | out_valid;
      end
      checkOutput(tag("no_second_block"), 64'(any_valid), 64'(0));

      // Reset while a block is in flight: it must vanish.
      applyStimulus(BW'($urandom), BW'($urandom), 1'b0, '0, 1'b0);
      reset = 1'b1;
      #1;
      checkOutput(tag("in_ready_reset_mid"), 64'(in_ready), 64'(0));
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput(tag("mid_rst_out_valid"), 64'(out_valid), 64'(0));
      checkOutput(tag("mid_rst_out_data"), 64'(out_data), 64'(0));
      checkOutput(tag("mid_rst_in_ready"), 64'(in_ready), 64'(1));
      any_valid = 1'b0;
      repeat (RN + 3) begin
        @(negedge clock);
        any_valid = any_valid | out_valid;
      end
      checkOutput(tag("discarded_block"), 64'(any_valid), 64'(0));

      // Encrypt/decrypt round trips; decrypt must return the original plaintext.
      for (int n = 0; n < NPAIRS; n++) begin
        data = (BW <= 8) ? BW'(n) : BW'($urandom);
        key  = BW'($urandom);
        ct   = BW'(ref_cipher(HW, RN, int'(data), int'(key), 1'b0));
        applyStimulus(data, key, 1'b0, ct, 1'b1);
        collectResult(0);
        applyStimulus(ct, key, 1'b1, data, 1'b1);
        collectResult(0);
      end
      finished = 1'b1;
    end
  end

  initial begin
    int cyc = 0;
    while (done_vec !== {NCFG{1'b1}} && cyc < 60000) begin
      @(posedge clock);
      cyc++;
    end
    checkOutput("all_configs_done", 64'(done_vec), 64'({NCFG{1'b1}}));
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
